// File: rtl/aia_pkg.sv
// Shared AIA parameters and the APLIC MSI forwarding FSM state type.
package aia_pkg;
    localparam int UserNrSources = 256;
    localparam int UserNrHarts   = 5;
    localparam int EiidWidth     = 11;

    typedef enum logic [1:0] {IDLE, READ, CHECK, SEND} aplic_msi_state_e;
endpackage

// File: rtl/aplic_rr_picker.sv
// Rotating priority encoder: lowest eligible index >= ptr, else lowest eligible overall.
module aplic_rr_picker #(
    parameter  int NrSources = 256,
    localparam int SrcW      = $clog2(NrSources)
) (
    input  logic [NrSources-1:0] i_eligible,
    input  logic [SrcW-1:0]      i_ptr,
    output logic [SrcW-1:0]      o_idx,
    output logic                 o_found
);
    logic [SrcW-1:0] idx_hi, idx_lo;
    logic            found_hi;

    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        o_found  = 1'b0;
        for (int i = NrSources - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                idx_lo  = SrcW'(i);
                o_found = 1'b1;
                if (i >= int'(i_ptr)) begin
                    idx_hi   = SrcW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        o_idx = found_hi ? idx_hi : idx_lo;
    end
endmodule

// File: rtl/aplic_msi_scheduler.sv
// APLIC MSI-mode forwarding engine: round-robin pick, target fetch, one MSI write per pick.
module aplic_msi_scheduler
    import aia_pkg::*;
#(
    parameter  int NrSources = aia_pkg::UserNrSources,
    parameter  int NrHarts   = aia_pkg::UserNrHarts,
    parameter  int EiidW     = aia_pkg::EiidWidth,
    localparam int SrcW      = $clog2(NrSources),
    localparam int HartW     = $clog2(NrHarts)
) (
    input  logic                 i_clk,
    input  logic                 ni_rst,
    input  logic                 i_domain_ie,
    input  logic [NrSources-1:0] i_pending,
    input  logic [NrSources-1:0] i_enabled,
    output logic                 o_tgt_req,
    output logic [SrcW-1:0]      o_tgt_idx,
    input  logic [HartW-1:0]     i_tgt_hart,
    input  logic [EiidW-1:0]     i_tgt_eiid,
    output logic                 o_msi_valid,
    input  logic                 i_msi_ready,
    output logic [HartW-1:0]     o_msi_hart,
    output logic [EiidW-1:0]     o_msi_eiid,
    output logic                 o_clr_valid,
    output logic [SrcW-1:0]      o_clr_idx
);
    aplic_msi_state_e state_q, state_d;
    logic [SrcW-1:0]  idx_q, idx_d, ptr_q, ptr_d, ptr_next;
    logic [HartW-1:0] hart_q, hart_d;
    logic [EiidW-1:0] eiid_q, eiid_d;

    logic [NrSources-1:0] eligible;
    logic [SrcW-1:0]      pick_idx;
    logic                 pick_found;
    logic                 clr;

    always_comb begin
        eligible    = i_pending & i_enabled;
        eligible[0] = 1'b0;
    end

    aplic_rr_picker #(.NrSources(NrSources)) u_picker (
        .i_eligible (eligible),
        .i_ptr      (ptr_q),
        .o_idx      (pick_idx),
        .o_found    (pick_found)
    );

    // Pointer never lands on reserved source 0.
    assign ptr_next = (idx_q == SrcW'(NrSources - 1)) ? SrcW'(1) : idx_q + SrcW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hart_d  = hart_q;
        eiid_d  = eiid_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_domain_ie && pick_found) begin
                    idx_d   = pick_idx;
                    state_d = READ;
                end
            end
            READ: state_d = CHECK;
            CHECK: begin
                if (!eligible[idx_q] || !i_domain_ie) begin
                    state_d = IDLE;
                end else if (i_tgt_eiid == '0 || int'(i_tgt_hart) >= NrHarts) begin
                    clr     = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else begin
                    hart_d  = i_tgt_hart;
                    eiid_d  = i_tgt_eiid;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Committed: only the handshake ends this state.
                if (i_msi_ready) begin
                    clr     = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= SrcW'(1);
            hart_q  <= '0;
            eiid_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hart_q  <= hart_d;
            eiid_q  <= eiid_d;
        end
    end

    assign o_tgt_req   = (state_q == READ);
    assign o_tgt_idx   = (state_q != IDLE) ? idx_q : '0;
    assign o_clr_idx   = (state_q != IDLE) ? idx_q : '0;
    assign o_clr_valid = clr;
    assign o_msi_valid = (state_q == SEND);
    assign o_msi_hart  = (state_q == SEND) ? hart_q : '0;
    assign o_msi_eiid  = (state_q == SEND) ? eiid_q : '0;
endmodule

// File: tb/tb_aplic_msi_scheduler.sv
// Directed per-cycle vectors for aplic_msi_scheduler plus a hand-written async-reset sequence.
module tb_aplic_msi_scheduler;
    logic         i_clk = 1'b0;
    logic         ni_rst;
    logic         i_domain_ie;
    logic [255:0] i_pending, i_enabled;
    logic         o_tgt_req;
    logic [7:0]   o_tgt_idx;
    logic [2:0]   i_tgt_hart;
    logic [10:0]  i_tgt_eiid;
    logic         o_msi_valid;
    logic         i_msi_ready;
    logic [2:0]   o_msi_hart;
    logic [10:0]  o_msi_eiid;
    logic         o_clr_valid;
    logic [7:0]   o_clr_idx;

    // Target register file model
    logic [2:0]  thart [256];
    logic [10:0] teiid [256];
    assign i_tgt_hart = thart[o_tgt_idx];
    assign i_tgt_eiid = teiid[o_tgt_idx];

    always #5 i_clk = ~i_clk;

    aplic_msi_scheduler dut (
        .i_clk       (i_clk),
        .ni_rst      (ni_rst),
        .i_domain_ie (i_domain_ie),
        .i_pending   (i_pending),
        .i_enabled   (i_enabled),
        .o_tgt_req   (o_tgt_req),
        .o_tgt_idx   (o_tgt_idx),
        .i_tgt_hart  (i_tgt_hart),
        .i_tgt_eiid  (i_tgt_eiid),
        .o_msi_valid (o_msi_valid),
        .i_msi_ready (i_msi_ready),
        .o_msi_hart  (o_msi_hart),
        .o_msi_eiid  (o_msi_eiid),
        .o_clr_valid (o_clr_valid),
        .o_clr_idx   (o_clr_idx)
    );

    typedef logic [32:0] obs_t;
    obs_t obs;
    assign obs = {o_tgt_req, o_tgt_idx, o_msi_valid, o_msi_hart, o_msi_eiid, o_clr_valid, o_clr_idx};

    typedef struct {
        int   a, b;
        bit   ie, rdy;
        obs_t exp;
    } vec_t;
    vec_t tbl[$];

    int n_cmp = 0, n_err = 0;

    function automatic obs_t mk(bit req, int idx, bit vld, int hart, int eiid, bit clr);
        return {req, 8'(idx), vld, 3'(hart), 11'(eiid), clr, 8'(idx)};
    endfunction

    task automatic r(int a, int b, bit ie, bit rdy, bit req, int idx, bit vld, int hart, int eiid, bit clr);
        vec_t v;
        v.a = a; v.b = b; v.ie = ie; v.rdy = rdy;
        v.exp = mk(req, idx, vld, hart, eiid, clr);
        tbl.push_back(v);
    endtask

    task automatic drive(int a, int b, bit ie, bit rdy);
        i_pending = '0;
        i_enabled = '0;
        if (a != 0) begin i_pending[a] = 1'b1; i_enabled[a] = 1'b1; end
        if (b != 0) begin i_pending[b] = 1'b1; i_enabled[b] = 1'b1; end
        i_domain_ie = ie;
        i_msi_ready = rdy;
    endtask

    task automatic chk(string nm, obs_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got req=%0b tidx=%0d vld=%0b hart=%0d eiid=%0d clr=%0b cidx=%0d, want req=%0b tidx=%0d vld=%0b hart=%0d eiid=%0d clr=%0b cidx=%0d",
                     nm, obs[32], obs[31:24], obs[23], obs[22:20], obs[19:9], obs[8], obs[7:0],
                     exp[32], exp[31:24], exp[23], exp[22:20], exp[19:9], exp[8], exp[7:0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin thart[i] = '0; teiid[i] = '0; end
        thart[5] = 2;   teiid[5] = 17;
        thart[3] = 1;   teiid[3] = 33;
        thart[200] = 4; teiid[200] = 100;
        thart[9] = 0;   teiid[9] = 0;
        thart[10] = 7;  teiid[10] = 5;
        thart[254] = 1; teiid[254] = 254;
        thart[255] = 3; teiid[255] = 255;
        thart[1] = 0;   teiid[1] = 1;

        // Single source 5, ready high (ptr 1 -> 6)
        r(5, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        r(5, 0, 1, 1, 1, 5, 0, 0, 0, 0);
        r(5, 0, 1, 1, 0, 5, 0, 0, 0, 0);
        r(5, 0, 1, 1, 0, 5, 1, 2, 17, 1);
        r(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // Sources 3 and 200 alternate (ptr 6 -> 200 first)
        for (int k = 0; k < 2; k++) begin
            r(3, 200, 1, 1, 0, 0, 0, 0, 0, 0);
            r(3, 200, 1, 1, 1, 200, 0, 0, 0, 0);
            r(3, 200, 1, 1, 0, 200, 0, 0, 0, 0);
            r(3, 200, 1, 1, 0, 200, 1, 4, 100, 1);
            r(3, 200, 1, 1, 0, 0, 0, 0, 0, 0);
            r(3, 200, 1, 1, 1, 3, 0, 0, 0, 0);
            r(3, 200, 1, 1, 0, 3, 0, 0, 0, 0);
            r(3, 200, 1, 1, 0, 3, 1, 1, 33, 1);
        end
        r(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // Backpressure on source 3 (ptr 4, wraps to 3)
        r(3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        r(3, 0, 1, 0, 1, 3, 0, 0, 0, 0);
        r(3, 0, 1, 0, 0, 3, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) r(3, 0, 1, 0, 0, 3, 1, 1, 33, 0);
        r(3, 0, 1, 1, 0, 3, 1, 1, 33, 1);
        r(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // Drops: 9 has EIID 0, 10 has hart 7 (ptr 4 -> 10 -> 11)
        r(9, 10, 1, 1, 0, 0, 0, 0, 0, 0);
        r(9, 10, 1, 1, 1, 9, 0, 0, 0, 0);
        r(9, 10, 1, 1, 0, 9, 0, 0, 0, 1);
        r(10, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        r(10, 0, 1, 1, 1, 10, 0, 0, 0, 0);
        r(10, 0, 1, 1, 0, 10, 0, 0, 0, 1);
        r(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // CHECK aborts: un-pended, then domain IE low; no clear, ptr stays 11
        r(5, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        r(5, 0, 1, 1, 1, 5, 0, 0, 0, 0);
        r(0, 0, 1, 1, 0, 5, 0, 0, 0, 0);
        r(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        r(5, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        r(5, 0, 1, 1, 1, 5, 0, 0, 0, 0);
        r(5, 0, 0, 1, 0, 5, 0, 0, 0, 0);
        // IE low blocks selection; once sent, request survives IE/pending loss
        r(5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        r(5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        r(5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        r(5, 0, 1, 0, 1, 5, 0, 0, 0, 0);
        r(5, 0, 1, 0, 0, 5, 0, 0, 0, 0);
        r(0, 0, 0, 0, 0, 5, 1, 2, 17, 0);
        r(0, 0, 0, 0, 0, 5, 1, 2, 17, 0);
        r(0, 0, 0, 1, 0, 5, 1, 2, 17, 1);
        r(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Wrap: 254 brings ptr to 255, then 255 before 1
        r(254, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        r(254, 0, 1, 1, 1, 254, 0, 0, 0, 0);
        r(254, 0, 1, 1, 0, 254, 0, 0, 0, 0);
        r(254, 0, 1, 1, 0, 254, 1, 1, 254, 1);
        r(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        r(255, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        r(255, 1, 1, 1, 1, 255, 0, 0, 0, 0);
        r(255, 1, 1, 1, 0, 255, 0, 0, 0, 0);
        r(255, 1, 1, 1, 0, 255, 1, 3, 255, 1);
        r(255, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        r(255, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        r(255, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        r(255, 1, 1, 1, 0, 1, 1, 0, 1, 1);
        r(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        ni_rst = 1'b0;
        drive(0, 0, 1, 1);
        repeat (2) @(negedge i_clk);
        #1 chk("reset", mk(0, 0, 0, 0, 0, 0));
        ni_rst = 1'b1;

        // Source 0 and a pending-but-disabled source are never picked
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            drive(0, 0, 1, 1);
            i_pending[0] = 1'b1; i_enabled[0] = 1'b1; i_pending[7] = 1'b1;
            #1 chk($sformatf("inelig%0d", k), mk(0, 0, 0, 0, 0, 0));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge i_clk);
            drive(tbl[i].a, tbl[i].b, tbl[i].ie, tbl[i].rdy);
            #1 chk($sformatf("row%0d", i), tbl[i].exp);
        end

        // Async reset mid-SEND (ptr is 2 here, so 255 is picked)
        @(negedge i_clk); drive(255, 0, 1, 0); #1 chk("rs_idle", mk(0, 0, 0, 0, 0, 0));
        @(negedge i_clk); #1 chk("rs_read", mk(1, 255, 0, 0, 0, 0));
        @(negedge i_clk); #1 chk("rs_check", mk(0, 255, 0, 0, 0, 0));
        @(negedge i_clk); #1 chk("rs_send", mk(0, 255, 1, 3, 255, 0));
        #1 ni_rst = 1'b0;
        #1 chk("rs_async", mk(0, 0, 0, 0, 0, 0));
        @(negedge i_clk); drive(255, 1, 1, 0); ni_rst = 1'b1;
        #1 chk("rs_after", mk(0, 0, 0, 0, 0, 0));
        @(negedge i_clk); #1 chk("rs_ptr1", mk(1, 1, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aplic_msi_scheduler.md
# aplic_msi_scheduler

Forwarding engine for an APLIC interrupt domain in MSI delivery mode: selects one pending-and-enabled source by round-robin, fetches its target (hart index, EIID) from the APLIC register file, and issues one MSI write request towards the IMSIC side under a valid/ready handshake. It clears the source's pending bit when the MSI is accepted or dropped. One instance per domain, between the APLIC gateway/register file and the MSI bus master.

## Interface
- NrSources, aia_pkg::UserNrSources (256): interrupt sources incl. reserved source 0
- NrHarts, aia_pkg::UserNrHarts (5): valid hart indices 0..NrHarts-1
- EiidWidth, aia_pkg::EiidWidth (11): external interrupt identity width
- Derived: SrcW = $clog2(NrSources), HartW = $clog2(NrHarts)

- i_clk  in  1  clock
- ni_rst  in  1  asynchronous, active-low reset
- i_domain_ie  in  1  domaincfg.IE of this domain
- i_pending  in  NrSources  per-source pending bits
- i_enabled  in  NrSources  per-source enable bits
- o_tgt_req  out  1  target read strobe
- o_tgt_idx  out  SrcW  source whose target register is read
- i_tgt_hart  in  HartW  target hart index, valid one cycle after o_tgt_req
- i_tgt_eiid  in  EiidWidth  target EIID, same timing
- o_msi_valid  out  1  MSI write request valid
- i_msi_ready  in  1  MSI master accepts request
- o_msi_hart  out  HartW  destination hart
- o_msi_eiid  out  EiidWidth  MSI data (EIID)
- o_clr_valid  out  1  one-cycle pulse: clear pending of o_clr_idx
- o_clr_idx  out  SrcW  source to clear

## Operation
- Eligible(i) = i_pending[i] & i_enabled[i] & (i != 0). Source 0 never eligible.
- Round-robin pointer ptr, range 1..NrSources-1: selection = lowest eligible index >= ptr, else lowest eligible index < ptr (wrap).
- FSM states: IDLE, READ, CHECK, SEND.
  - IDLE: if i_domain_ie and any eligible: latch selection into idx, go READ. Else stay.
  - READ: o_tgt_req=1, o_tgt_idx=idx; go CHECK.
  - CHECK: sample i_tgt_hart/i_tgt_eiid. If source idx no longer eligible, or i_domain_ie=0: go IDLE, no clear, ptr unchanged. Else if i_tgt_eiid==0 or i_tgt_hart>=NrHarts: drop — pulse o_clr_valid for idx, ptr=idx+1 (wrap to 1), go IDLE. Else load o_msi_hart/o_msi_eiid, go SEND.
  - SEND: o_msi_valid=1; payload stable. On i_msi_ready: o_clr_valid pulse for idx in same cycle, ptr=idx+1 (wrap: NrSources-1 → 1), go IDLE.
- Once o_msi_valid is asserted the request is committed: it is not withdrawn if the source is disabled, un-pended, or i_domain_ie falls.
- o_tgt_idx and o_clr_idx hold idx in all non-IDLE states.

## Timing
- Reset (ni_rst low, asynchronous): state IDLE, ptr=1, idx=0, all outputs 0.
- Reset mid-SEND: o_msi_valid drops immediately; no clear pulse; request lost (pending stays set and is re-forwarded after reset).
- Eligible visible in IDLE at cycle N → o_tgt_req at N+1 → CHECK at N+2 → o_msi_valid at N+3.
- Handshake at cycle M (valid & ready) → o_clr_valid at M (combinational from state & i_msi_ready), IDLE at M+1, next o_msi_valid earliest M+4.
- Drop path: o_clr_valid in CHECK cycle (N+2), next selection at N+3.
- Throughput: at most one MSI per 4 cycles.
- i_msi_ready while not SEND: ignored.

## Structure
- aia_pkg additions: localparam EiidWidth = 11; typedef enum logic [1:0] {IDLE, READ, CHECK, SEND} aplic_msi_state_e.
- Sub-module aplic_rr_picker: combinational rotating priority encoder (NrSources-wide eligible vector, ptr in, idx + found out); reusable by direct-mode delivery.

## Test plan
- Single source 5 pending+enabled, target hart 2 / EIID 17, ready tied high → o_msi_valid 3 cycles later with hart 2, EIID 17; o_clr_valid with idx 5 in handshake cycle.
- Sources 3 and 200 held eligible, ready high → MSIs alternate 3, 200, 3, 200; none starved.
- Backpressure: ready low 6 cycles during SEND → o_msi_valid, o_msi_hart, o_msi_eiid stable; single clear pulse only on acceptance.
- Source 9 with EIID 0, and source 10 with hart 7 → no o_msi_valid; o_clr_valid for 9 and 10; ptr advances.
- i_domain_ie=0 with sources eligible → no o_tgt_req; deassert after o_msi_valid rises → request still completes.
- Only source 255 then source 1 eligible, ptr at 255 → order 255 then 1 (wrap); assert ni_rst during SEND → outputs 0 asynchronously, ptr=1 after release.
